// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio tone driver.
package audio_pkg;

  localparam int unsigned CLK_FREQ     = 100_000_000;
  localparam int unsigned BEAT_FREQ    = 8;
  localparam int unsigned BEAT_LEN     = 32;
  localparam logic [15:0] AMP          = 16'h2000;
  localparam int unsigned TONE_MAX     = 20_000;
  localparam int unsigned SILENCE_TONE = 50_000_000;

  localparam int unsigned AccW  = 27;
  localparam int unsigned BeatW = 12;

  function automatic logic [15:0] neg_amp(input logic [15:0] a);
    return 16'(~a + 16'd1);
  endfunction

endpackage

// File: rtl/tone_osc.sv
// One audio channel: phase accumulator, silence detection and registered square-wave sample.
module tone_osc
  import audio_pkg::*;
#(
  parameter int unsigned ClkFreq = CLK_FREQ,
  parameter logic [15:0] Amp     = AMP,
  parameter int unsigned ToneMax = TONE_MAX
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] tone_i,
  output logic [15:0] sample_o
);

  logic [AccW-1:0] acc_q, acc_d;
  logic [15:0]     sample_q, sample_d;
  logic            silent;
  logic [31:0]     sum;

  always_comb begin
    silent   = !en_i || (tone_i == '0) || (tone_i >= ToneMax);
    sum      = {{(32 - AccW){1'b0}}, acc_q} + tone_i;
    acc_d    = '0;
    sample_d = '0;
    // Audible tone changes keep the running phase; only silence clears it.
    if (!silent) begin
      acc_d    = (sum >= ClkFreq) ? AccW'(sum - ClkFreq) : AccW'(sum);
      sample_d = (acc_d >= AccW'(ClkFreq / 2)) ? Amp : neg_amp(Amp);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      sample_q <= '0;
    end else begin
      acc_q    <= acc_d;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/audio_tone_driver.sv
// Song beat counter, two square-wave tone oscillators and an I2S master serializer.
module audio_tone_driver #(
  parameter int unsigned CLK_FREQ  = audio_pkg::CLK_FREQ,
  parameter int unsigned BEAT_FREQ = audio_pkg::BEAT_FREQ,
  parameter int unsigned BEAT_LEN  = audio_pkg::BEAT_LEN,
  parameter logic [15:0] AMP       = audio_pkg::AMP,
  parameter int unsigned TONE_MAX  = audio_pkg::TONE_MAX
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [31:0]                 toneL,
  input  logic [31:0]                 toneR,
  output logic [audio_pkg::BeatW-1:0] beatNum,
  output logic                        audio_mclk,
  output logic                        audio_lrck,
  output logic                        audio_sck,
  output logic                        audio_sdin
);

  localparam int unsigned BeatDiv = CLK_FREQ / BEAT_FREQ;

  logic [31:0]                 div_q, div_d;
  logic [audio_pkg::BeatW-1:0] beat_q, beat_d;
  logic [8:0]                  cnt_q, cnt_d;
  logic [31:0]                 frame_q, frame_d;
  logic                        sdin_q, sdin_d;
  logic [4:0]                  bit_idx;
  logic [15:0]                 sample_l, sample_r;

  tone_osc #(
    .ClkFreq (CLK_FREQ),
    .Amp     (AMP),
    .ToneMax (TONE_MAX)
  ) u_osc_l (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .tone_i   (toneL),
    .sample_o (sample_l)
  );

  tone_osc #(
    .ClkFreq (CLK_FREQ),
    .Amp     (AMP),
    .ToneMax (TONE_MAX)
  ) u_osc_r (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .tone_i   (toneR),
    .sample_o (sample_r)
  );

  always_comb begin
    div_d  = div_q;
    beat_d = beat_q;
    if (!en) begin
      div_d  = '0;
      beat_d = '0;
    end else if (div_q == 32'(BeatDiv - 1)) begin
      div_d  = '0;
      beat_d = (beat_q == audio_pkg::BeatW'(BEAT_LEN - 1)) ? '0 : beat_q + 1'b1;
    end else begin
      div_d = div_q + 32'd1;
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 9'd1;
    frame_d = (cnt_q == '0) ? {sample_l, sample_r} : frame_q;
    // Slot k carries bit 32-k mod 32; slot 0 is loaded at cnt=511, so it still sees the old word.
    bit_idx = 5'd0 - cnt_d[8:4];
    sdin_d  = (cnt_d[3:0] == '0) ? frame_q[bit_idx] : sdin_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      sdin_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      sdin_q  <= sdin_d;
    end
  end

  assign beatNum    = beat_q;
  assign audio_mclk = cnt_q[1];
  assign audio_sck  = cnt_q[3];
  assign audio_lrck = cnt_q[8];
  assign audio_sdin = sdin_q;

endmodule
